// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment readback monitor.
package seg_pkg;

    localparam int unsigned SEG_W   = 8;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned VAL_W   = 4;

    // Segment bus bit positions
    localparam int unsigned SEG_DP = 7;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_A  = 0;

    // Active-high gfedcba glyphs for hex values 0..F
    localparam logic [GLYPH_W-1:0] GLYPH_0     = 7'h3F;
    localparam logic [GLYPH_W-1:0] GLYPH_1     = 7'h06;
    localparam logic [GLYPH_W-1:0] GLYPH_2     = 7'h5B;
    localparam logic [GLYPH_W-1:0] GLYPH_3     = 7'h4F;
    localparam logic [GLYPH_W-1:0] GLYPH_4     = 7'h66;
    localparam logic [GLYPH_W-1:0] GLYPH_5     = 7'h6D;
    localparam logic [GLYPH_W-1:0] GLYPH_6     = 7'h7D;
    localparam logic [GLYPH_W-1:0] GLYPH_7     = 7'h07;
    localparam logic [GLYPH_W-1:0] GLYPH_8     = 7'h7F;
    localparam logic [GLYPH_W-1:0] GLYPH_9     = 7'h6F;
    localparam logic [GLYPH_W-1:0] GLYPH_A     = 7'h77;
    localparam logic [GLYPH_W-1:0] GLYPH_B     = 7'h7C;
    localparam logic [GLYPH_W-1:0] GLYPH_C     = 7'h39;
    localparam logic [GLYPH_W-1:0] GLYPH_D     = 7'h5E;
    localparam logic [GLYPH_W-1:0] GLYPH_E     = 7'h79;
    localparam logic [GLYPH_W-1:0] GLYPH_F     = 7'h71;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 7'h00;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic             hit;
        logic [VAL_W-1:0] value;
    } glyph_dec_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Maps a normalized (active-high) 7-bit segment pattern back to its hex value.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [GLYPH_W-1:0] pattern,
    output glyph_dec_t         dec_c
);

    always_comb begin
        dec_c = '{hit: 1'b1, value: 4'h0};
        case (pattern)
            GLYPH_0:     dec_c.value = 4'h0;
            GLYPH_1:     dec_c.value = 4'h1;
            GLYPH_2:     dec_c.value = 4'h2;
            GLYPH_3:     dec_c.value = 4'h3;
            GLYPH_4:     dec_c.value = 4'h4;
            GLYPH_5:     dec_c.value = 4'h5;
            GLYPH_6:     dec_c.value = 4'h6;
            GLYPH_7:     dec_c.value = 4'h7;
            GLYPH_8:     dec_c.value = 4'h8;
            GLYPH_9:     dec_c.value = 4'h9;
            GLYPH_A:     dec_c.value = 4'hA;
            GLYPH_B:     dec_c.value = 4'hB;
            GLYPH_C:     dec_c.value = 4'hC;
            GLYPH_D:     dec_c.value = 4'hD;
            GLYPH_E:     dec_c.value = 4'hE;
            GLYPH_F:     dec_c.value = 4'hF;
            GLYPH_BLANK: dec_c.hit   = 1'b0;
            default:     dec_c.hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_digit_monitor.sv
// Samples and debounces a 7-segment bus, decodes stable glyphs and tracks
// the direction of successive digit changes.
module seg_digit_monitor
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [SEG_W-1:0] Segment,
    output logic [VAL_W-1:0] Digit_out,
    output logic             DP_out,
    output logic             Valid,
    output logic             Invalid,
    output logic             Dir_up,
    output logic             Dir_down,
    output logic             Step_err,
    output logic [CNT_W-1:0] Change_count
);

    localparam int unsigned      STB_W    = 4;
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
    localparam logic [SEG_W-1:0] POL_MASK = {SEG_W{ACTIVE_LOW}};

    logic [SEG_W-1:0] seg_q;
    logic [STB_W-1:0] seg_cnt, dp_cnt;
    logic [STB_W-1:0] seg_cnt_nxt, dp_cnt_nxt;
    logic             seg_same_c, dp_same_c;
    logic             seg_reach_c, dp_reach_c;
    logic             seg_hit_q, dp_hit_q;
    logic [SEG_W-1:0] seg_norm_c;
    glyph_dec_t       dec_c;

    mon_state_e       state, state_nxt;
    logic [VAL_W-1:0] digit_nxt, digit_inc_c, digit_dec_c;
    logic             dp_nxt, valid_nxt, invalid_nxt;
    logic             up_nxt, down_nxt, step_nxt;
    logic [CNT_W-1:0] count_nxt;

    // Stability counters: glyph bits and DP are filtered independently
    always_comb begin
        seg_same_c  = (Segment[SEG_G:SEG_A] == seg_q[SEG_G:SEG_A]);
        dp_same_c   = (Segment[SEG_DP] == seg_q[SEG_DP]);
        seg_cnt_nxt = STB_ONE;
        dp_cnt_nxt  = STB_ONE;
        if (seg_same_c) seg_cnt_nxt = (seg_cnt >= STB_MAX) ? STB_MAX : seg_cnt + STB_ONE;
        if (dp_same_c)  dp_cnt_nxt  = (dp_cnt  >= STB_MAX) ? STB_MAX : dp_cnt  + STB_ONE;
        // Reaching the threshold counts once per stable run, even when it is 1
        seg_reach_c = (seg_cnt_nxt == STB_MAX) && (!seg_same_c || seg_cnt != STB_MAX);
        dp_reach_c  = (dp_cnt_nxt  == STB_MAX) && (!dp_same_c  || dp_cnt  != STB_MAX);
    end

    assign seg_norm_c = seg_q ^ POL_MASK;

    seg_glyph_decode u_decode (
        .pattern (seg_norm_c[SEG_G:SEG_A]),
        .dec_c   (dec_c)
    );

    assign digit_inc_c = Digit_out + VAL_W'(1);
    assign digit_dec_c = Digit_out - VAL_W'(1);

    // Acceptance, direction classification and tracking FSM
    always_comb begin
        state_nxt   = state;
        digit_nxt   = Digit_out;
        dp_nxt      = DP_out;
        valid_nxt   = 1'b0;
        invalid_nxt = Invalid;
        up_nxt      = 1'b0;
        down_nxt    = 1'b0;
        step_nxt    = 1'b0;
        count_nxt   = Change_count;

        if (dp_hit_q) dp_nxt = seg_norm_c[SEG_DP];

        if (seg_hit_q) begin
            if (!dec_c.hit) begin
                invalid_nxt = 1'b1;
            end else begin
                invalid_nxt = 1'b0;
                case (state)
                    WAIT_FIRST: begin
                        digit_nxt = dec_c.value;
                        valid_nxt = 1'b1;
                        state_nxt = TRACK;
                    end
                    TRACK: begin
                        if (dec_c.value != Digit_out) begin
                            digit_nxt = dec_c.value;
                            valid_nxt = 1'b1;
                            count_nxt = Change_count + CNT_W'(1);
                            if (dec_c.value == digit_inc_c)      up_nxt   = 1'b1;
                            else if (dec_c.value == digit_dec_c) down_nxt = 1'b1;
                            else                                 step_nxt = 1'b1;
                        end
                    end
                    default: state_nxt = WAIT_FIRST;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            seg_q        <= '0;
            seg_cnt      <= '0;
            dp_cnt       <= '0;
            seg_hit_q    <= 1'b0;
            dp_hit_q     <= 1'b0;
            state        <= WAIT_FIRST;
            Digit_out    <= '0;
            DP_out       <= 1'b0;
            Valid        <= 1'b0;
            Invalid      <= 1'b0;
            Dir_up       <= 1'b0;
            Dir_down     <= 1'b0;
            Step_err     <= 1'b0;
            Change_count <= '0;
        end else begin
            seg_q        <= Segment;
            seg_cnt      <= seg_cnt_nxt;
            dp_cnt       <= dp_cnt_nxt;
            seg_hit_q    <= seg_reach_c;
            dp_hit_q     <= dp_reach_c;
            state        <= state_nxt;
            Digit_out    <= digit_nxt;
            DP_out       <= dp_nxt;
            Valid        <= valid_nxt;
            Invalid      <= invalid_nxt;
            Dir_up       <= up_nxt;
            Dir_down     <= down_nxt;
            Step_err     <= step_nxt;
            Change_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_seg_digit_monitor.sv
// Directed self-checking bench for seg_digit_monitor (default parameters).
module tb_seg_digit_monitor;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic [7:0] Segment = 8'hFF;
    logic [3:0] Digit_out;
    logic       DP_out, Valid, Invalid, Dir_up, Dir_down, Step_err;
    logic [7:0] Change_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    int nv, nu, nd, ns;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 Clk = ~Clk;

    seg_digit_monitor #(.STABLE_CYCLES(2), .ACTIVE_LOW(1'b1), .CNT_W(8)) dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .Segment      (Segment),
        .Digit_out    (Digit_out),
        .DP_out       (DP_out),
        .Valid        (Valid),
        .Invalid      (Invalid),
        .Dir_up       (Dir_up),
        .Dir_down     (Dir_down),
        .Step_err     (Step_err),
        .Change_count (Change_count)
    );

    // Active-low bus value for hex digit d with decimal point dp
    function automatic logic [7:0] seg_of(input int d, input logic dp);
        return ~{dp, glyph_tab[d]};
    endfunction

    task automatic clear_counts();
        nv = 0; nu = 0; nd = 0; ns = 0;
    endtask

    // Drive s for cyc cycles, tallying output pulses sampled 1ns after each edge
    task automatic hold(input logic [7:0] s, input int cyc);
        Segment = s;
        repeat (cyc) begin
            @(posedge Clk); #1;
            if (Valid)    nv++;
            if (Dir_up)   nu++;
            if (Dir_down) nd++;
            if (Step_err) ns++;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        total_cnt++; if (Digit_out !== 4'h0) $display("FAIL reset_digit: got %h exp 0", Digit_out); else pass_cnt++;
        total_cnt++; if ({DP_out, Valid, Invalid, Dir_up, Dir_down, Step_err} !== 6'b0)
            $display("FAIL reset_flags: got %b exp 000000", {DP_out, Valid, Invalid, Dir_up, Dir_down, Step_err});
        else pass_cnt++;
        total_cnt++; if (Change_count !== 8'd0) $display("FAIL reset_count: got %0d exp 0", Change_count); else pass_cnt++;
    endtask

    task automatic test_first_digit();
        logic [3:0] vv;
        logic [3:0] dirs;
        vv = '0; dirs = '0;
        Segment = seg_of(0, 1'b0);
        nReset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            vv[i] = Valid;
            dirs[i] = Dir_up | Dir_down | Step_err;
        end
        total_cnt++; if (vv !== 4'b0100) $display("FAIL first_valid_timing: got %b exp 0100", vv); else pass_cnt++;
        total_cnt++; if (dirs !== 4'b0000) $display("FAIL first_no_dir: got %b exp 0000", dirs); else pass_cnt++;
        total_cnt++; if (Digit_out !== 4'h0) $display("FAIL first_digit: got %h exp 0", Digit_out); else pass_cnt++;
        total_cnt++; if (Change_count !== 8'd0) $display("FAIL first_count: got %0d exp 0", Change_count); else pass_cnt++;
    endtask

    task automatic test_count_up();
        clear_counts();
        for (int d = 1; d <= 16; d++) hold(seg_of(d % 16, 1'b0), 4);
        total_cnt++; if (nv !== 16) $display("FAIL up_valid_count: got %0d exp 16", nv); else pass_cnt++;
        total_cnt++; if (nu !== 16 || nd !== 0 || ns !== 0)
            $display("FAIL up_dirs: got up=%0d down=%0d step=%0d exp 16/0/0", nu, nd, ns);
        else pass_cnt++;
        total_cnt++; if (Digit_out !== 4'h0) $display("FAIL up_digit: got %h exp 0", Digit_out); else pass_cnt++;
        total_cnt++; if (Change_count !== 8'd16) $display("FAIL up_count: got %0d exp 16", Change_count); else pass_cnt++;
    endtask

    task automatic test_count_down();
        hold(seg_of(1, 1'b0), 4);
        clear_counts();
        hold(seg_of(0, 1'b0), 4);
        hold(seg_of(15, 1'b0), 4);
        total_cnt++; if (Digit_out !== 4'hF) $display("FAIL wrap_down_digit: got %h exp F", Digit_out); else pass_cnt++;
        hold(seg_of(14, 1'b0), 4);
        total_cnt++; if (nv !== 3 || nd !== 3 || nu !== 0 || ns !== 0)
            $display("FAIL down_dirs: got v=%0d up=%0d down=%0d step=%0d exp 3/0/3/0", nv, nu, nd, ns);
        else pass_cnt++;
        total_cnt++; if (Digit_out !== 4'hE) $display("FAIL down_digit: got %h exp E", Digit_out); else pass_cnt++;
        total_cnt++; if (Change_count !== 8'd20) $display("FAIL down_count: got %0d exp 20", Change_count); else pass_cnt++;
    endtask

    task automatic test_step_invalid();
        clear_counts();
        hold(seg_of(5, 1'b0), 4);
        hold(seg_of(12, 1'b0), 4);
        total_cnt++; if (nv !== 2 || ns !== 2 || nu !== 0 || nd !== 0)
            $display("FAIL step_err: got v=%0d up=%0d down=%0d step=%0d exp 2/0/0/2", nv, nu, nd, ns);
        else pass_cnt++;
        total_cnt++; if (Digit_out !== 4'hC) $display("FAIL step_digit: got %h exp C", Digit_out); else pass_cnt++;
        clear_counts();
        hold(8'hFF, 4);
        total_cnt++; if (Invalid !== 1'b1) $display("FAIL blank_invalid: got %b exp 1", Invalid); else pass_cnt++;
        total_cnt++; if (Digit_out !== 4'hC || nv !== 0)
            $display("FAIL blank_hold: got digit=%h valid=%0d exp C/0", Digit_out, nv);
        else pass_cnt++;
        hold(seg_of(11, 1'b0), 4);
        total_cnt++; if (Invalid !== 1'b0) $display("FAIL invalid_clear: got %b exp 0", Invalid); else pass_cnt++;
        total_cnt++; if (nv !== 1 || nd !== 1 || Digit_out !== 4'hB)
            $display("FAIL after_blank: got v=%0d down=%0d digit=%h exp 1/1/B", nv, nd, Digit_out);
        else pass_cnt++;
        total_cnt++; if (Change_count !== 8'd23) $display("FAIL step_count: got %0d exp 23", Change_count); else pass_cnt++;
    endtask

    task automatic test_glitch_dp();
        logic [3:0] dpv;
        dpv = '0;
        hold(seg_of(5, 1'b0), 4);
        clear_counts();
        hold(seg_of(7, 1'b0), 1);
        hold(seg_of(5, 1'b0), 4);
        total_cnt++; if (nv !== 0 || Digit_out !== 4'h5)
            $display("FAIL glitch_reject: got valid=%0d digit=%h exp 0/5", nv, Digit_out);
        else pass_cnt++;
        Segment = seg_of(5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            dpv[i] = DP_out;
            if (Valid) nv++;
        end
        total_cnt++; if (dpv !== 4'b1100) $display("FAIL dp_rise_timing: got %b exp 1100", dpv); else pass_cnt++;
        hold(seg_of(5, 1'b0), 4);
        total_cnt++; if (DP_out !== 1'b0) $display("FAIL dp_fall: got %b exp 0", DP_out); else pass_cnt++;
        total_cnt++; if (nv !== 0) $display("FAIL dp_no_valid: got %0d exp 0", nv); else pass_cnt++;
        total_cnt++; if (Change_count !== 8'd24) $display("FAIL glitch_count: got %0d exp 24", Change_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear_counts();
        Segment = seg_of(9, 1'b0);
        @(posedge Clk); #1;
        nReset = 1'b0;
        #1;
        total_cnt++; if (Digit_out !== 4'h0 || Change_count !== 8'd0)
            $display("FAIL mid_reset_regs: got digit=%h count=%0d exp 0/0", Digit_out, Change_count);
        else pass_cnt++;
        total_cnt++; if ({DP_out, Valid, Invalid, Dir_up, Dir_down, Step_err} !== 6'b0)
            $display("FAIL mid_reset_flags: got %b exp 000000", {DP_out, Valid, Invalid, Dir_up, Dir_down, Step_err});
        else pass_cnt++;
        @(posedge Clk); #1;
        nReset = 1'b1;
        hold(seg_of(9, 1'b0), 4);
        total_cnt++; if (nv !== 1 || (nu + nd + ns) !== 0)
            $display("FAIL post_reset_first: got v=%0d dirs=%0d exp 1/0", nv, nu + nd + ns);
        else pass_cnt++;
        total_cnt++; if (Digit_out !== 4'h9 || Change_count !== 8'd0)
            $display("FAIL post_reset_state: got digit=%h count=%0d exp 9/0", Digit_out, Change_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_digit();
        test_count_up();
        test_count_down();
        test_step_invalid();
        test_glitch_dp();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg_digit_monitor.md
Name: seg_digit_monitor

Overview:
- Receiving end of the hex digit counter's 7-segment bus: samples the 8-bit Segment output, filters transients, and decodes stable glyphs back to a 4-bit hex value.
- Infers count direction from consecutive digits and flags illegal glyphs and non-unit jumps.
- Sits beside the display driver as an on-chip self-check and readback path for count state.

Parameters:
- STABLE_CYCLES, 2, consecutive identical samples required before a pattern is accepted (legal range 1..15).
- ACTIVE_LOW, 1, 1 = segments active-low (common anode); 0 = active-high.
- CNT_W, 8, width of Change_count.

Ports:
- Clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Segment  input  8  display bus: [7]=DP, [6:0]={g,f,e,d,c,b,a}; polarity set by ACTIVE_LOW.
- Digit_out  output  4  last accepted hex value.
- DP_out  output  1  stabilized decimal point, active-high.
- Valid  output  1  one-cycle pulse: new digit accepted.
- Invalid  output  1  level: current stable 7-bit pattern is not a legal glyph.
- Dir_up  output  1  one-cycle pulse with Valid: new = old+1 mod 16.
- Dir_down  output  1  one-cycle pulse with Valid: new = old-1 mod 16.
- Step_err  output  1  one-cycle pulse with Valid: new differs from old by more than +/-1 mod 16.
- Change_count  output  CNT_W  number of accepted digit changes, wraps to 0.

Behaviour:
- Reset (async, nReset=0):
  - Digit_out=0, DP_out=0, Valid=0, Invalid=0, Dir_up=0, Dir_down=0, Step_err=0, Change_count=0.
  - Sample register and stability counter clear; FSM enters WAIT_FIRST.
  - Reset asserted mid-operation aborts any pending acceptance.
- Input handling:
  - Segment is registered every edge, then normalized to active-high (inverted when ACTIVE_LOW=1).
  - The stability counter compares the 7 segment bits only (DP excluded):
    - equal to previous sample -> counter increments, saturating at STABLE_CYCLES;
    - different -> counter reloads to 1.
- Latency: a pattern presented before edge n and held gives Valid high during the cycle after edge n+STABLE_CYCLES. That is 3 cycles for the default.
- Glyph table (active-high gfedcba), decoded to values 0..F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71. Any other pattern, including blank 00, is illegal.
- Acceptance happens on the cycle the stability counter first reaches STABLE_CYCLES:
  - Legal glyph whose value differs from Digit_out, or FSM in WAIT_FIRST: load Digit_out and pulse Valid.
  - Legal glyph equal to Digit_out: no pulse.
  - Illegal pattern: set Invalid, leave Digit_out unchanged, no Valid.
  - Invalid clears on the next accepted legal pattern.
- FSM states:
  - WAIT_FIRST: the first legal acceptance pulses Valid only (no direction pulse, Change_count unchanged), then moves to TRACK.
  - TRACK: each Valid carries exactly one of Dir_up, Dir_down or Step_err, and Change_count increments.
- Wrap-around: F->0 is Dir_up; 0->F is Dir_down.
- Illegal patterns between two legal digits do not reset tracking. The direction compare uses the last legal Digit_out.
- DP is filtered separately with its own STABLE_CYCLES counter:
  - DP_out updates after the same latency;
  - a DP-only change never produces Valid.
- A pattern that changes before reaching STABLE_CYCLES is discarded with no output effect (glitch rejection).

Decomposition:
- Shared package seg_pkg holds:
  - the 16 glyph constants;
  - the blank constant;
  - the FSM state encoding (WAIT_FIRST, TRACK);
  - the segment bit-index constants (SEG_DP=7, SEG_G=6 ... SEG_A=0).
- One natural sub-module, seg_glyph_decode: combinational 7-bit normalized pattern -> {hit, value[3:0]}.
- Filtering, FSM and direction logic stay in seg_digit_monitor.

Test Plan:
- Reset, then hold Segment=~8'h3F (digit 0, active-low) -> Valid pulses once, 3 cycles after the first sample edge; Digit_out=0; no Dir pulses; Change_count=0.
- From digit 0, drive 1, 2 ... F, 0, each for 4 cycles -> 16 Valid pulses, all with Dir_up; Digit_out=0 at the end; Change_count=16.
- Load 1, then drive 0, F, E -> Dir_down on each step, including the 0->F wrap; Digit_out=E.
- Drive 5 then C -> Step_err with Valid; Digit_out=C. Then drive ~8'h00 (blank) for 4 cycles -> Invalid=1, Digit_out stays C. Then drive B -> Invalid=0, Dir_down.
- Hold 5, then a 1-cycle glitch to 7, then back to 5 -> no Valid; Digit_out=5. Separately toggle DP only -> DP_out follows after 3 cycles with no Valid.
- Assert nReset mid-stream while a new digit has been stable only 1 cycle -> all outputs 0 immediately; after release, the first legal digit gives Valid with no Dir pulse.
